// File: rtl/serial_frame_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_frame_tx_if                                            |
// | Description : Producer-side handshake and line signals of serial_frame_tx.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              send;
  logic              ready;
  logic              tx;
  logic              done;

  // Byte producer drives data/send and watches the transmitter status.
  modport master (
    output data_in,
    output send,
    input  ready,
    input  tx,
    input  done
  );

  // Transmitter consumes data/send and drives the line and status.
  modport slave (
    input  data_in,
    input  send,
    output ready,
    output tx,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_frame_tx                                               |
// | Description : Async serial frame transmitter: start, DATA_W bits LSB first, |
// |               optional parity, STOP_BITS stop bits, BIT_TICKS clocks/bit.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module serial_frame_tx #(
  parameter int BIT_TICKS  = 20,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  wire logic         clk_br,
  input  wire logic         rst_n,
  serial_frame_tx_if.slave  bus
);

  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] c_TICK_LAST = TW'(BIT_TICKS - 1);
  // Done is registered, so it is raised one tick ahead of the final stop cycle.
  localparam logic [TW-1:0] c_TICK_PRE  = TW'(BIT_TICKS - 2);
  localparam logic [TW-1:0] c_TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] c_BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] c_BIT_ONE   = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state;
  logic [TW-1:0]     r_tick;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic              r_stop_idx;
  logic              r_tx;
  logic              r_done;

  logic              w_parity;
  logic [DATA_W-1:0] w_shift_next;
  logic              w_stop_last;
  logic              w_tick_last;

  assign w_parity     = (PARITY_ODD != 0) ? ~^bus.data_in : ^bus.data_in;
  assign w_shift_next = r_shift >> 1;
  assign w_stop_last  = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;
  assign w_tick_last  = (r_tick == c_TICK_LAST);

  assign bus.ready = (r_state == S_IDLE);
  assign bus.tx    = r_tx;
  assign bus.done  = r_done;

  // Frame sequencer: state, bit timing, shift register and registered line outputs.
  always_ff @(posedge clk_br) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tick     <= '0;
          r_bit      <= '0;
          r_stop_idx <= 1'b0;
          r_tx       <= 1'b1;
          if (bus.send) begin
            r_shift  <= bus.data_in;
            r_parity <= w_parity;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_tick_last) begin
            r_tick  <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_tick <= r_tick + c_TICK_ONE;
          end
        end
        S_DATA: begin
          if (w_tick_last) begin
            r_tick  <= '0;
            r_shift <= w_shift_next;
            if (r_bit == c_BIT_LAST) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit <= r_bit + c_BIT_ONE;
              r_tx  <= w_shift_next[0];
            end
          end else begin
            r_tick <= r_tick + c_TICK_ONE;
          end
        end
        S_PARITY: begin
          if (w_tick_last) begin
            r_tick     <= '0;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
            r_state    <= S_STOP;
          end else begin
            r_tick <= r_tick + c_TICK_ONE;
          end
        end
        S_STOP: begin
          if (w_stop_last && (r_tick == c_TICK_PRE)) begin
            r_done <= 1'b1;
          end
          if (w_tick_last) begin
            r_tick <= '0;
            if (w_stop_last) begin
              r_state <= S_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_tick <= r_tick + c_TICK_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_serial_frame_tx                                            |
// | Description : Self-checking bench for serial_frame_tx; four configurations   |
// |               compared cycle by cycle against a bit-list frame model.        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_serial_frame_tx;

  localparam int NONE = -10;

  logic       clk_br = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] send_v;
  logic [7:0] data_v [4];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  bit exp_q [$];

  always #5 clk_br = ~clk_br;

  // a: defaults, b: odd parity, c: no parity, d: tiny frame with two stop bits
  serial_frame_tx_if #(.DATA_W(8)) if_a ();
  serial_frame_tx_if #(.DATA_W(8)) if_b ();
  serial_frame_tx_if #(.DATA_W(8)) if_c ();
  serial_frame_tx_if #(.DATA_W(1)) if_d ();

  assign if_a.send    = send_v[0];
  assign if_a.data_in = data_v[0];
  assign if_b.send    = send_v[1];
  assign if_b.data_in = data_v[1];
  assign if_c.send    = send_v[2];
  assign if_c.data_in = data_v[2];
  assign if_d.send    = send_v[3];
  assign if_d.data_in = data_v[3][0];

  serial_frame_tx u_a (.clk_br(clk_br), .rst_n(rst_n), .bus(if_a));
  serial_frame_tx #(.PARITY_ODD(1)) u_b (.clk_br(clk_br), .rst_n(rst_n), .bus(if_b));
  serial_frame_tx #(.PARITY_EN(0)) u_c (.clk_br(clk_br), .rst_n(rst_n), .bus(if_c));
  serial_frame_tx #(.BIT_TICKS(2), .DATA_W(1), .STOP_BITS(2)) u_d (
    .clk_br(clk_br), .rst_n(rst_n), .bus(if_d));

  // {ready, tx, done} of the selected instance
  function automatic logic [2:0] obs(int s);
    case (s)
      0:       return {if_a.ready, if_a.tx, if_a.done};
      1:       return {if_b.ready, if_b.tx, if_b.done};
      2:       return {if_c.ready, if_c.tx, if_c.done};
      default: return {if_d.ready, if_d.tx, if_d.done};
    endcase
  endfunction

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_br);
    #1;
    cyc++;
  endtask

  // Expected frame as a list of bit values; each lasts BIT_TICKS cycles.
  task automatic build_model(input logic [15:0] d, input int dw, input int pen,
                             input int podd, input int sb);
    bit par;
    par   = 1'b0;
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      exp_q.push_back(d[i]);
      par ^= d[i];
    end
    if (pen != 0) exp_q.push_back((podd != 0) ? ~par : par);
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
  endtask

  task automatic idle_check(int sel, int n, string tag);
    logic [2:0] o;
    for (int i = 0; i < n; i++) begin
      o = obs(sel);
      chk({tag, " idle tx"}, int'(o[1]), 1);
      chk({tag, " idle ready"}, int'(o[2]), 1);
      chk({tag, " idle done"}, int'(o[0]), 0);
      step();
    end
  endtask

  task automatic start_frame(int sel, logic [7:0] d, bit hold, string tag);
    logic [2:0] o;
    o = obs(sel);
    chk({tag, " pre ready"}, int'(o[2]), 1);
    data_v[sel] = d;
    send_v[sel] = 1'b1;
    step();
    if (!hold) send_v[sel] = 1'b0;
  endtask

  // Called in the first cycle after accept; walks the whole frame cycle by cycle.
  task automatic run_frame(int sel, int bt, int exp_len, int inj_at, logic [7:0] inj_d,
                           int abort_at, string tag);
    logic [2:0] o;
    int len;
    len      = exp_q.size() * bt;
    fall_cyc = cyc;
    for (int k = 0; k < len; k++) begin
      o = obs(sel);
      chk({tag, " tx"}, int'(o[1]), int'(exp_q[k / bt]));
      chk({tag, " done"}, int'(o[0]), (k == len - 1) ? 1 : 0);
      chk({tag, " ready"}, int'(o[2]), 0);
      if (o[0]) done_cyc = cyc;
      if (k == abort_at) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        o = obs(sel);
        chk({tag, " abort tx"}, int'(o[1]), 1);
        chk({tag, " abort ready"}, int'(o[2]), 1);
        chk({tag, " abort done"}, int'(o[0]), 0);
        return;
      end
      if (k == inj_at) begin
        send_v[sel] = 1'b1;
        data_v[sel] = inj_d;
      end
      if (k == inj_at + 1) send_v[sel] = 1'b0;
      step();
    end
    chk({tag, " frame length"}, done_cyc - fall_cyc + 1, exp_len);
  endtask

  initial begin
    logic [2:0] o;
    logic [7:0] d;
    int         d1;
    send_v = '0;
    for (int i = 0; i < 4; i++) data_v[i] = '0;

    // Reset state of every instance
    step();
    step();
    for (int s = 0; s < 4; s++) begin
      o = obs(s);
      chk("reset tx", int'(o[1]), 1);
      chk("reset ready", int'(o[2]), 1);
      chk("reset done", int'(o[0]), 0);
    end

    // send coincident with reset is not accepted
    send_v[0] = 1'b1;
    data_v[0] = 8'hA5;
    step();
    send_v[0] = 1'b0;
    rst_n     = 1'b1;
    step();
    idle_check(0, 2, "send-in-reset");

    // Defaults with 8'hA5
    start_frame(0, 8'hA5, 1'b0, "a5");
    build_model(16'h00A5, 8, 1, 0, 1);
    run_frame(0, 20, 220, NONE, 8'h00, NONE, "a5");
    idle_check(0, 3, "a5");

    // Parity polarity and parity-less frame
    start_frame(1, 8'h01, 1'b0, "odd01");
    build_model(16'h0001, 8, 1, 1, 1);
    run_frame(1, 20, 220, NONE, 8'h00, NONE, "odd01");
    start_frame(0, 8'h01, 1'b0, "even01");
    build_model(16'h0001, 8, 1, 0, 1);
    run_frame(0, 20, 220, NONE, 8'h00, NONE, "even01");
    start_frame(2, 8'hFF, 1'b0, "nopar");
    build_model(16'h00FF, 8, 0, 0, 1);
    run_frame(2, 20, 200, NONE, 8'h00, NONE, "nopar");
    idle_check(2, 2, "nopar");

    // send with a new byte mid-frame is ignored
    start_frame(0, 8'hA5, 1'b0, "busy");
    build_model(16'h00A5, 8, 1, 0, 1);
    run_frame(0, 20, 220, 49, 8'h3C, NONE, "busy");
    idle_check(0, 5, "busy");

    // Reset at tick 7 of data bit 3, then a full frame
    d = 8'($urandom);
    start_frame(0, d, 1'b0, "abort");
    build_model({8'h00, d}, 8, 1, 0, 1);
    run_frame(0, 20, 220, NONE, 8'h00, 4 * 20 + 7, "abort");
    idle_check(0, 2, "abort");
    d = 8'($urandom);
    start_frame(0, d, 1'b0, "post-abort");
    build_model({8'h00, d}, 8, 1, 0, 1);
    run_frame(0, 20, 220, NONE, 8'h00, NONE, "post-abort");

    // Back-to-back with send held high
    start_frame(0, 8'h55, 1'b1, "b2b1");
    data_v[0] = 8'hAA;
    build_model(16'h0055, 8, 1, 0, 1);
    run_frame(0, 20, 220, NONE, 8'h00, NONE, "b2b1");
    d1 = done_cyc;
    o = obs(0);
    chk("b2b gap tx", int'(o[1]), 1);
    chk("b2b gap ready", int'(o[2]), 1);
    step();
    send_v[0] = 1'b0;
    build_model(16'h00AA, 8, 1, 0, 1);
    run_frame(0, 20, 220, NONE, 8'h00, NONE, "b2b2");
    chk("b2b done spacing", done_cyc - d1, 221);
    idle_check(0, 2, "b2b");

    // Tiny configuration, random data bit
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(1, 0));
      start_frame(3, d, 1'b0, "tiny");
      build_model({8'h00, d}, 1, 1, 0, 2);
      run_frame(3, 2, 10, NONE, 8'h00, NONE, "tiny");
    end
    idle_check(3, 2, "tiny");

    // Random bytes with a random ignored request inside the frame
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      start_frame(0, d, 1'b0, "rand");
      build_model({8'h00, d}, 8, 1, 0, 1);
      run_frame(0, 20, 220, $urandom_range(200, 1), 8'($urandom), NONE, "rand");
      idle_check(0, 3, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
